// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
//   Shared types and sizing helpers for the staged reset sequencer.
//   - state_t     : sequencer FSM states
//   - cnt_width() : width of the shared hold/timeout counter
//   - idx_width() : width of a stage index (at least 1 bit)
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_RUN      = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    // Wide enough to hold max(hold_cycles, ack_timeout) without wrapping.
    function automatic int cnt_width(input int hold_cycles, input int ack_timeout);
        int m;
        m = (hold_cycles > ack_timeout) ? hold_cycles : ack_timeout;
        return $clog2(m + 1);
    endfunction

    function automatic int idx_width(input int num_stages);
        return (num_stages > 1) ? $clog2(num_stages) : 1;
    endfunction

endpackage

// File: rtl/reset_seq_if.sv
// reset_seq_if
//   Bundle between the reset sequencer and the blocks it releases.
//   - soft_reset_req : restart request (sync, >=1 cycle)
//   - stage_ack      : per-stage ready
//   - stage_reset    : per-stage active-high reset, bit 0 released first
//   - all_released   : every stage out of reset and acknowledged
//   - fault          : ack timeout occurred
//   - fault_stage    : index of the stage that timed out
//   modport master : the sequencer side
//   modport slave  : the system side (button path + sequenced blocks)
interface reset_seq_if #(
    parameter int NUM_STAGES = 4
);
    import reset_seq_pkg::*;

    localparam int IDX_W = idx_width(NUM_STAGES);

    logic                  soft_reset_req;
    logic [NUM_STAGES-1:0] stage_ack;
    logic [NUM_STAGES-1:0] stage_reset;
    logic                  all_released;
    logic                  fault;
    logic [IDX_W-1:0]      fault_stage;

    modport master (
        input  soft_reset_req,
        input  stage_ack,
        output stage_reset,
        output all_released,
        output fault,
        output fault_stage
    );

    modport slave (
        output soft_reset_req,
        output stage_ack,
        input  stage_reset,
        input  all_released,
        input  fault,
        input  fault_stage
    );

endinterface

// File: rtl/reset_seq_timer.sv
// reset_seq_timer
//   Clearable, saturating up-counter with terminal-match output.
//   - clk, rst : clock, async active-high reset
//   - clr      : synchronous clear (wins over counting)
//   - limit    : terminal count
//   - hit      : high when the count on this edge reaches limit, so the
//                owner can act on the same edge the limit is reached
module reset_seq_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   count_inc;

    assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
    assign hit       = (count_inc >= {1'b0, limit});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (count != {CNT_W{1'b1}}) begin
            count <= count_inc[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/reset_seq.sv
// reset_seq
//   Staged reset sequencer. Holds every stage in reset for HOLD_CYCLES,
//   then releases stages one at a time, waiting for each stage's ack
//   before releasing the next. A missing ack for ACK_TIMEOUT cycles puts
//   the whole vector back into reset and latches a fault with the stage
//   index. soft_reset_req restarts the sequence from any state.
//   - clk      : system clock, rising edge
//   - reset_in : async active-high reset from the power-on generator
//   - bus      : reset_seq_if master modport (req/ack in, resets/status out)
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset_in,
    reset_seq_if.master  bus
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, ACK_TIMEOUT);
    localparam int IDX_W = idx_width(NUM_STAGES);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    state_t                state_q,        state_d;
    logic [IDX_W-1:0]      idx_q,          idx_d;
    logic [NUM_STAGES-1:0] stage_reset_q,  stage_reset_d;
    logic                  all_released_q, all_released_d;
    logic                  fault_q,        fault_d;
    logic [IDX_W-1:0]      fault_stage_q,  fault_stage_d;

    logic             tmr_clr;
    logic [CNT_W-1:0] tmr_limit;
    logic             tmr_hit;
    logic             ack_cur;

    // One counter serves both the hold and the ack-timeout phases.
    reset_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (reset_in),
        .clr   (tmr_clr),
        .limit (tmr_limit),
        .hit   (tmr_hit)
    );

    assign tmr_limit = (state_q == ST_HOLD) ? HOLD_LIM : ACK_LIM;
    assign ack_cur   = bus.stage_ack[idx_q];

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q        <= ST_HOLD;
            idx_q          <= '0;
            stage_reset_q  <= '1;
            all_released_q <= 1'b0;
            fault_q        <= 1'b0;
            fault_stage_q  <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            stage_reset_q  <= stage_reset_d;
            all_released_q <= all_released_d;
            fault_q        <= fault_d;
            fault_stage_q  <= fault_stage_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        stage_reset_d  = stage_reset_q;
        all_released_d = all_released_q;
        fault_d        = fault_q;
        fault_stage_d  = fault_stage_q;
        tmr_clr        = 1'b0;

        if (bus.soft_reset_req) begin
            // Restart beats ack, timeout and hold completion.
            state_d        = ST_HOLD;
            idx_d          = '0;
            stage_reset_d  = '1;
            all_released_d = 1'b0;
            fault_d        = 1'b0;
            fault_stage_d  = '0;
            tmr_clr        = 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (tmr_hit) begin
                        // Released stages form a low-order run of zeros,
                        // so a left shift releases exactly the next one.
                        stage_reset_d = stage_reset_q << 1;
                        idx_d         = '0;
                        tmr_clr       = 1'b1;
                        state_d       = ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_cur) begin
                        tmr_clr = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            all_released_d = 1'b1;
                            state_d        = ST_RUN;
                        end else begin
                            stage_reset_d = stage_reset_q << 1;
                            idx_d         = idx_q + 1'b1;
                        end
                    end else if (tmr_hit) begin
                        fault_d       = 1'b1;
                        fault_stage_d = idx_q;
                        stage_reset_d = '1;
                        tmr_clr       = 1'b1;
                        state_d       = ST_FAULT;
                    end
                end
                // RUN and FAULT are parked; keep the counter idle.
                default: tmr_clr = 1'b1;
            endcase
        end
    end

    assign bus.stage_reset  = stage_reset_q;
    assign bus.all_released = all_released_q;
    assign bus.fault        = fault_q;
    assign bus.fault_stage  = fault_stage_q;

endmodule

// File: tb/tb_reset_seq.sv
module tb_reset_seq;

    localparam int N = 3;
    localparam int H = 4;
    localparam int T = 8;

    logic clk;
    logic reset_in;

    reset_seq_if #(.NUM_STAGES(N)) bus ();

    reset_seq #(
        .NUM_STAGES  (N),
        .HOLD_CYCLES (H),
        .ACK_TIMEOUT (T)
    ) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: count of released stages, hold/wait progress in
    // edges, plus the parked flags.
    int m_rel, m_hold, m_since, m_fstage;
    bit m_done, m_flt;
    int edge_no;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_rel = 0; m_hold = 0; m_since = 0; m_fstage = 0;
        m_done = 0; m_flt = 0;
    endtask

    // Advance the model by one rising edge using the inputs present now.
    task automatic model_edge();
        if (reset_in) begin
            model_clear();
        end else if (bus.soft_reset_req) begin
            model_clear();
        end else if (m_flt || m_done) begin
            // parked
        end else if (m_rel == 0) begin
            m_hold++;
            if (m_hold == H) begin
                m_rel   = 1;
                m_since = 0;
            end
        end else if (bus.stage_ack[m_rel-1]) begin
            if (m_rel == N) m_done = 1;
            else begin
                m_rel++;
                m_since = 0;
            end
        end else begin
            m_since++;
            if (m_since == T) begin
                m_flt    = 1;
                m_fstage = m_rel - 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_sr;
        exp_sr = '1;
        if (!m_flt) exp_sr = exp_sr << m_rel;
        chk("stage_reset",  int'(bus.stage_reset), int'(exp_sr));
        chk("all_released", int'(bus.all_released), int'(m_done));
        chk("fault",        int'(bus.fault), int'(m_flt));
        chk("fault_stage",  int'(bus.fault_stage), m_fstage);
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        edge_no++;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic soft_pulse();
        bus.soft_reset_req = 1'b1;
        tick();
        bus.soft_reset_req = 1'b0;
    endtask

    // Assert reset_in between edges, check it acts without a clock,
    // hold it across one edge, then release so the next edge is edge 1.
    task automatic async_reset();
        #3;
        reset_in = 1'b1;
        #1;
        model_clear();
        check_outputs();
        tick();
        reset_in = 1'b0;
        edge_no  = 0;
    endtask

    int first_rel;

    initial begin
        reset_in           = 1'b1;
        bus.soft_reset_req = 1'b0;
        bus.stage_ack      = '0;
        edge_no            = 0;
        model_clear();

        // Reset values before any clock edge.
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        reset_in = 1'b0;
        edge_no  = 0;

        // Normal sequence with constant acks; all_released expected at edge H+N.
        bus.stage_ack = 3'b111;
        first_rel = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.all_released && first_rel < 0) first_rel = edge_no;
        end
        chk("release_edge", first_rel, H + N);

        // Soft reset from RUN, then a repeat of the sequence.
        soft_pulse();
        ticks(10);

        // Delayed ack on stage 1: stage 1 released at edge H+1, ack 3 cycles later.
        bus.stage_ack = 3'b101;
        soft_pulse();
        ticks(H + 1 + 3);
        bus.stage_ack = 3'b111;
        ticks(6);

        // Timeout on stage 1, then 20 cycles parked in FAULT.
        bus.stage_ack = 3'b101;
        soft_pulse();
        ticks(H + 1 + T + 20);

        // Soft reset out of FAULT.
        bus.stage_ack = 3'b111;
        soft_pulse();
        ticks(10);

        // Soft request held high keeps the block in HOLD.
        bus.soft_reset_req = 1'b1;
        ticks(6);
        bus.soft_reset_req = 1'b0;

        // Collision: final ack and soft request on the same edge.
        bus.stage_ack = 3'b011;
        ticks(H + 2);
        bus.stage_ack = 3'b111;
        soft_pulse();
        ticks(3);

        // Async reset mid-sequence.
        ticks(H + 1);
        async_reset();
        ticks(10);

        // Randomized traffic: segments with differing ack density.
        for (int seg = 0; seg < 12; seg++) begin
            int dens;
            dens = $urandom_range(1, 8);
            for (int c = 0; c < 120; c++) begin
                logic [N-1:0] a;
                for (int b = 0; b < N; b++) a[b] = ($urandom_range(0, 7) < dens);
                bus.stage_ack      = a;
                bus.soft_reset_req = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 249) == 0) begin
                    bus.soft_reset_req = 1'b0;
                    async_reset();
                end else begin
                    tick();
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
